muldiv_unit: RTL

- Iterative multiply/divide unit for the MIPS datapath, with architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Operands come from the register-file read ports. HI/LO results are read back by the datapath's mfhi/mflo mux.
- Parametrised in data width. One operation is in flight at a time, under a start/busy/done handshake.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_iter.sv | 32 +++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the MIPS multiply/divide unit: op codes, FSM states and
// the iteration-step mode.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } mode_t;

  function automatic logic is_div(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Combinational radix-2 step: shift-add multiply or restoring shift-subtract
// divide on a {upper, lower} 2*WIDTH accumulator.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mag_i,
  input  mode_t              mode_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, mag_i} : '0);
    // Upper half of {acc, 0}: partial remainder shifted left by one.
    shl  = acc_i[2*WIDTH-1:WIDTH-1];
    diff = shl - {1'b0, mag_i};
    if (mode_i == MODE_MUL) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {shl[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// MTHI/MTLO writes and a start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  mode_t               mode_q, mode_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  op_t                 op_c;
  logic                sgn;
  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [2*WIDTH-1:0]  acc_step;
  logic [2*WIDTH-1:0]  prod;
  logic [WIDTH-1:0]    quot, rem;

  assign op_c  = op_t'(op);
  assign sgn   = is_signed_op(op_c);
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .acc_i (acc_q),
    .mag_i (mag_q),
    .mode_i(mode_q),
    .acc_o (acc_step)
  );

  // Most-negative / -1 needs no special case: the magnitude quotient is
  // 2^(WIDTH-1) with a positive sign, which wraps to most-negative.
  assign prod = qneg_q ? -acc_q : acc_q;
  assign quot = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    mode_d  = mode_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op_c)
            OP_MULT, OP_MULTU: begin
              acc_d   = {{WIDTH{1'b0}}, b_mag};
              mag_d   = a_mag;
              mode_d  = MODE_MUL;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = 1'b0;
              cnt_d   = CNT_W'(WIDTH);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                hi_d   = a;
                lo_d   = '1;
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, a_mag};
                mag_d   = b_mag;
                mode_d  = MODE_DIV;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                cnt_d   = CNT_W'(WIDTH);
                state_d = RUN;
              end
            end
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (mode_q == MODE_MUL) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      mode_q  <= MODE_MUL;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      mode_q  <= mode_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
